// File: rtl/ex_alu_mc_pkg.sv
// ex_defs: shared operation codes and sequencer state encoding for the
// multi-cycle execute stage (ex_alu_mc) and its mul/div sequencer.
package ex_defs;

    // aluop codes
    localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
    localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
    localparam logic [7:0] EXE_SLT_OP   = 8'b0010_1010;
    localparam logic [7:0] EXE_SLTU_OP  = 8'b0010_1011;
    localparam logic [7:0] EXE_ADD_OP   = 8'b0010_0000;
    localparam logic [7:0] EXE_ADDU_OP  = 8'b0010_0001;
    localparam logic [7:0] EXE_SUB_OP   = 8'b0010_0010;
    localparam logic [7:0] EXE_SUBU_OP  = 8'b0010_0011;
    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;
    localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
    localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
    localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
    localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;

    // alusel result classes
    localparam logic [2:0] EXE_RES_NOP        = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC      = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT      = 3'b010;
    localparam logic [2:0] EXE_RES_MOVE       = 3'b011;
    localparam logic [2:0] EXE_RES_ARITHMETIC = 3'b100;
    localparam logic [2:0] EXE_RES_MUL        = 3'b101;

    // mul/div sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/ex_alu_mc_muldiv_seq.sv
// muldiv_seq: iterative multiply / restoring divide on operand magnitudes,
// followed by a sign fix-up cycle.
//   clk, rst      clock, synchronous active-low reset
//   start         accept a new operation (honoured only in IDLE)
//   is_div        1 = divide, 0 = multiply
//   is_signed     signed (MULT/DIV) versus unsigned (MULTU/DIVU)
//   op_a, op_b    multiplicand/multiplier or dividend/divisor
//   busy          sequencer not in IDLE
//   done          high during FIX; res_hi/res_lo are valid then
//   res_hi/res_lo upper/lower product, or remainder/quotient
module muldiv_seq
    import ex_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    seq_state_t state, state_nxt;

    logic [CNT_W-1:0]   cnt;
    // acc_hi: partial product upper half / partial remainder
    // acc_lo: multiplier shifting out / dividend shifting out, quotient in
    logic [WIDTH-1:0]   acc_hi, acc_lo;
    logic [WIDTH-1:0]   opnd;       // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   orig_a;     // raw dividend, returned as HI on /0
    logic               div_q, neg_main, neg_rem, div_zero;

    logic [WIDTH:0]     mul_sum, rem_sh;
    logic [WIDTH-1:0]   rem_diff;
    logic               rem_ge;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [2*WIDTH-1:0] prod, prod_fix;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic s);
        return (s && v[WIDTH-1]) ? -v : v;
    endfunction

    assign busy = (state != IDLE);
    assign done = (state == FIX);

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ITER;
            ITER:    if (cnt == '0) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One iteration: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        mul_sum  = {1'b0, acc_hi} + {1'b0, opnd};
        rem_sh   = {acc_hi, acc_lo[WIDTH-1]};
        rem_ge   = (rem_sh >= {1'b0, opnd});
        // true difference is below the divisor, so WIDTH bits suffice
        rem_diff = rem_sh[WIDTH-1:0] - opnd;
        if (div_q) begin
            step_hi = rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], rem_ge};
        end else if (acc_lo[0]) begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end else begin
            step_hi = {1'b0, acc_hi[WIDTH-1:1]};
            step_lo = {acc_hi[0], acc_lo[WIDTH-1:1]};
        end
    end

    // Sign correction applied in FIX.
    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_fix = neg_main ? -prod : prod;
        res_hi   = '0;
        res_lo   = '0;
        if (div_q) begin
            if (div_zero) begin
                res_hi = orig_a;
                res_lo = '1;
            end else begin
                res_hi = neg_rem  ? -acc_hi : acc_hi;
                res_lo = neg_main ? -acc_lo : acc_lo;
            end
        end else begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            orig_a   <= '0;
            div_q    <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
        end else if (state == IDLE && start) begin
            cnt      <= CNT_LAST;
            div_q    <= is_div;
            orig_a   <= op_a;
            acc_hi   <= '0;
            neg_main <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            neg_rem  <= is_signed & op_a[WIDTH-1];
            div_zero <= (op_b == '0);
            if (is_div) begin
                acc_lo <= magnitude(op_a, is_signed);
                opnd   <= magnitude(op_b, is_signed);
            end else begin
                acc_lo <= magnitude(op_b, is_signed);
                opnd   <= magnitude(op_a, is_signed);
            end
        end else if (state == ITER) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/ex_alu_mc.sv
// ex_alu_mc: multi-cycle MIPS32 execute stage. Single-cycle ALU ops are
// registered into the output stage; MULT/DIV run in muldiv_seq and write
// the private HI/LO pair.
//   clk, rst              clock, synchronous active-low reset
//   in_valid/in_ready     ID/EX handshake
//   aluop, alusel         operation code and result class
//   reg1, reg2            operands (reg2[4:0] = shift amount)
//   waddr, wr_en          destination register and write request
//   out_valid/out_ready   EX/MEM handshake
//   wdata_out, waddr_out, wr_en_out, ovf   registered result
//   hi, lo                architectural HI/LO
//   busy                  mul/div sequencer active
module ex_alu_mc
    import ex_defs::*;
#(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter int OP_W   = 8,
    parameter int SEL_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   aluop,
    input  logic [SEL_W-1:0]  alusel,
    input  logic [WIDTH-1:0]  reg1,
    input  logic [WIDTH-1:0]  reg2,
    input  logic [ADDR_W-1:0] waddr,
    input  logic              wr_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  wdata_out,
    output logic [ADDR_W-1:0] waddr_out,
    output logic              wr_en_out,
    output logic              ovf,
    output logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  lo,
    output logic              busy
);

    logic              accept, md_start, md_done, seq_busy;
    logic [WIDTH-1:0]  md_hi, md_lo;
    logic [ADDR_W-1:0] md_waddr;

    logic [WIDTH-1:0]  sum, diff, alu_res;
    int unsigned       shamt;
    logic              alu_known, alu_ovf;
    logic              is_md, md_div, md_signed, is_mthi, is_mtlo;

    assign in_ready = ~seq_busy & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;
    assign md_start = accept & is_md;
    assign busy     = seq_busy;

    assign sum  = reg1 + reg2;
    assign diff = reg1 - reg2;

    // A result op is recognised only when aluop and alusel agree.
    always_comb begin
        alu_res   = '0;
        alu_known = 1'b0;
        alu_ovf   = 1'b0;
        is_md     = 1'b0;
        md_div    = 1'b0;
        md_signed = 1'b0;
        is_mthi   = 1'b0;
        is_mtlo   = 1'b0;
        shamt     = {27'd0, reg2[4:0]} % 32'(WIDTH);
        case (aluop)
            EXE_OR_OP:  if (alusel == EXE_RES_LOGIC) begin alu_res = reg1 | reg2;    alu_known = 1'b1; end
            EXE_AND_OP: if (alusel == EXE_RES_LOGIC) begin alu_res = reg1 & reg2;    alu_known = 1'b1; end
            EXE_XOR_OP: if (alusel == EXE_RES_LOGIC) begin alu_res = reg1 ^ reg2;    alu_known = 1'b1; end
            EXE_NOR_OP: if (alusel == EXE_RES_LOGIC) begin alu_res = ~(reg1 | reg2); alu_known = 1'b1; end
            EXE_SLL_OP: if (alusel == EXE_RES_SHIFT) begin alu_res = reg1 << shamt;  alu_known = 1'b1; end
            EXE_SRL_OP: if (alusel == EXE_RES_SHIFT) begin alu_res = reg1 >> shamt;  alu_known = 1'b1; end
            EXE_SRA_OP: if (alusel == EXE_RES_SHIFT) begin
                alu_res   = $unsigned($signed(reg1) >>> shamt);
                alu_known = 1'b1;
            end
            EXE_SLT_OP: if (alusel == EXE_RES_ARITHMETIC) begin
                alu_res   = {{(WIDTH-1){1'b0}}, $signed(reg1) < $signed(reg2)};
                alu_known = 1'b1;
            end
            EXE_SLTU_OP: if (alusel == EXE_RES_ARITHMETIC) begin
                alu_res   = {{(WIDTH-1){1'b0}}, reg1 < reg2};
                alu_known = 1'b1;
            end
            EXE_ADD_OP: if (alusel == EXE_RES_ARITHMETIC) begin
                alu_res   = sum;
                alu_known = 1'b1;
                alu_ovf   = (reg1[WIDTH-1] == reg2[WIDTH-1]) && (sum[WIDTH-1] != reg1[WIDTH-1]);
            end
            EXE_ADDU_OP: if (alusel == EXE_RES_ARITHMETIC) begin alu_res = sum; alu_known = 1'b1; end
            EXE_SUB_OP: if (alusel == EXE_RES_ARITHMETIC) begin
                alu_res   = diff;
                alu_known = 1'b1;
                alu_ovf   = (reg1[WIDTH-1] != reg2[WIDTH-1]) && (diff[WIDTH-1] != reg1[WIDTH-1]);
            end
            EXE_SUBU_OP: if (alusel == EXE_RES_ARITHMETIC) begin alu_res = diff; alu_known = 1'b1; end
            EXE_MFHI_OP: if (alusel == EXE_RES_MOVE) begin alu_res = hi; alu_known = 1'b1; end
            EXE_MFLO_OP: if (alusel == EXE_RES_MOVE) begin alu_res = lo; alu_known = 1'b1; end
            EXE_MTHI_OP:  is_mthi = 1'b1;
            EXE_MTLO_OP:  is_mtlo = 1'b1;
            EXE_MULT_OP:  begin is_md = 1'b1; md_signed = 1'b1; end
            EXE_MULTU_OP: is_md = 1'b1;
            EXE_DIV_OP:   begin is_md = 1'b1; md_div = 1'b1; md_signed = 1'b1; end
            EXE_DIVU_OP:  begin is_md = 1'b1; md_div = 1'b1; end
            default: ;
        endcase
    end

    muldiv_seq #(.WIDTH(WIDTH)) u_seq (
        .clk       (clk),
        .rst       (rst),
        .start     (md_start),
        .is_div    (md_div),
        .is_signed (md_signed),
        .op_a      (reg1),
        .op_b      (reg2),
        .busy      (seq_busy),
        .done      (md_done),
        .res_hi    (md_hi),
        .res_lo    (md_lo)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            hi <= '0;
            lo <= '0;
        end else if (md_done) begin
            hi <= md_hi;
            lo <= md_lo;
        end else if (accept) begin
            if (is_mthi) hi <= reg1;
            if (is_mtlo) lo <= reg1;
        end
    end

    // Output stage: a mul/div completion and a new acceptance never coincide
    // because in_ready is low in FIX.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            wdata_out <= '0;
            waddr_out <= '0;
            wr_en_out <= 1'b0;
            ovf       <= 1'b0;
            md_waddr  <= '0;
        end else begin
            if (md_start) md_waddr <= waddr;
            if (md_done) begin
                out_valid <= 1'b1;
                wdata_out <= '0;
                waddr_out <= md_waddr;
                wr_en_out <= 1'b0;
                ovf       <= 1'b0;
            end else if (accept && !is_md) begin
                out_valid <= 1'b1;
                wdata_out <= alu_res;
                waddr_out <= waddr;
                wr_en_out <= wr_en & alu_known & ~alu_ovf;
                ovf       <= alu_ovf;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ex_alu_mc.sv
module tb_ex_alu_mc;
    import ex_defs::*;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic        wr_en, wr_en_out, ovf, busy;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1, reg2, wdata_out, hi, lo;
    logic [4:0]  waddr, waddr_out;

    always #5 clk = ~clk;

    ex_alu_mc #(.WIDTH(32), .ADDR_W(5), .OP_W(8), .SEL_W(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .aluop(aluop), .alusel(alusel), .reg1(reg1), .reg2(reg2),
        .waddr(waddr), .wr_en(wr_en), .out_valid(out_valid), .out_ready(out_ready),
        .wdata_out(wdata_out), .waddr_out(waddr_out), .wr_en_out(wr_en_out),
        .ovf(ovf), .hi(hi), .lo(lo), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  wa;
        logic        we;
        logic        ov;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every consumed result is compared against the queue head.
    always @(negedge clk) begin
        if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got wdata 0x%08h, expected no result", wdata_out);
            end else begin
                mon_e = sbq.pop_front();
                check("wdata_out", wdata_out, mon_e.data);
                check("waddr_out", 32'(waddr_out), 32'(mon_e.wa));
                check("wr_en_out", 32'(wr_en_out), 32'(mon_e.we));
                check("ovf", 32'(ovf), 32'(mon_e.ov));
            end
        end
    end

    task automatic issue(input logic [7:0] op, input logic [2:0] sel,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wa, input logic we);
        int n;
        aluop = op; alusel = sel; reg1 = a; reg2 = b; waddr = wa; wr_en = we;
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
                break;
            end
        end
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        // scramble operands: results must come from values captured at acceptance
        reg1 = $urandom;
        reg2 = $urandom;
    endtask

    task automatic run(input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wa, input logic we,
                       input logic [31:0] ed, input logic ewe, input logic eov);
        exp_t e;
        e.data = ed; e.wa = wa; e.we = ewe; e.ov = eov;
        sbq.push_back(e);
        issue(op, sel, a, b, wa, we);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL busy_timeout: busy stayed 1 for %0d cycles, expected 0", n);
                break;
            end
        end
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, inr_hi, seen;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        aluop = '0; alusel = '0; reg1 = '0; reg2 = '0; waddr = '0; wr_en = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_wdata", wdata_out, 0);
        check("rst_waddr", 32'(waddr_out), 0);
        check("rst_wr_en", 32'(wr_en_out), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b1;
        @(posedge clk);
        #2;

        // back-to-back logic ops
        run(EXE_OR_OP,  EXE_RES_LOGIC, 32'h0F0F0F0F, 32'h00FF00FF, 5'd3, 1'b1, 32'h0FFF0FFF, 1'b1, 1'b0);
        run(EXE_XOR_OP, EXE_RES_LOGIC, 32'h0F0F0F0F, 32'h00FF00FF, 5'd4, 1'b1, 32'h0FF00FF0, 1'b1, 1'b0);
        run(EXE_NOR_OP, EXE_RES_LOGIC, 32'h0F0F0F0F, 32'h00FF00FF, 5'd10, 1'b1, 32'hF000F000, 1'b1, 1'b0);
        run(EXE_AND_OP, EXE_RES_LOGIC, 32'h0F0F0F0F, 32'h00FF00FF, 5'd11, 1'b1, 32'h000F000F, 1'b1, 1'b0);
        // overflow behaviour
        run(EXE_ADD_OP,  EXE_RES_ARITHMETIC, 32'h7FFFFFFF, 32'h1, 5'd5, 1'b1, 32'h80000000, 1'b0, 1'b1);
        run(EXE_ADDU_OP, EXE_RES_ARITHMETIC, 32'h7FFFFFFF, 32'h1, 5'd5, 1'b1, 32'h80000000, 1'b1, 1'b0);
        run(EXE_SUB_OP,  EXE_RES_ARITHMETIC, 32'h80000000, 32'h1, 5'd9, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1);
        run(EXE_SUBU_OP, EXE_RES_ARITHMETIC, 32'h5, 32'h7, 5'd9, 1'b1, 32'hFFFFFFFE, 1'b1, 1'b0);
        // shifts and compares
        run(EXE_SRA_OP,  EXE_RES_SHIFT, 32'h80000000, 32'h4,  5'd12, 1'b1, 32'hF8000000, 1'b1, 1'b0);
        run(EXE_SRL_OP,  EXE_RES_SHIFT, 32'h80000000, 32'h3F, 5'd13, 1'b1, 32'h00000001, 1'b1, 1'b0);
        run(EXE_SLT_OP,  EXE_RES_ARITHMETIC, 32'hFFFFFFFF, 32'h1, 5'd14, 1'b1, 32'h1, 1'b1, 1'b0);
        run(EXE_SLTU_OP, EXE_RES_ARITHMETIC, 32'hFFFFFFFF, 32'h1, 5'd15, 1'b1, 32'h0, 1'b1, 1'b0);
        // unknown aluop
        run(8'hFF, EXE_RES_LOGIC, 32'h1, 32'h2, 5'd16, 1'b1, 32'h0, 1'b0, 1'b0);

        // MULT -3 * 7
        run(EXE_MULT_OP, EXE_RES_NOP, 32'hFFFFFFFD, 32'h7, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        n = 0; inr_hi = 0;
        forever begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (in_ready) inr_hi++;
            if (n > 100) break;
        end
        check("mult_busy_cycles", 32'(n), 33);
        check("mult_in_ready_while_busy", 32'(inr_hi), 0);
        @(posedge clk);
        #2;
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFEB);
        run(EXE_MFLO_OP, EXE_RES_MOVE, 32'h0, 32'h0, 5'd6, 1'b1, 32'hFFFFFFEB, 1'b1, 1'b0);

        // DIV -7 / 2 with MFHI queued straight behind it
        run(EXE_DIV_OP,  EXE_RES_NOP,  32'hFFFFFFF9, 32'h2, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        run(EXE_MFHI_OP, EXE_RES_MOVE, 32'h0, 32'h0, 5'd17, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
        check("div_lo", lo, 32'hFFFFFFFD);
        check("div_hi", hi, 32'hFFFFFFFF);

        // DIVU 5 / 0
        run(EXE_DIVU_OP, EXE_RES_NOP, 32'h5, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        wait_idle();
        check("divz_lo", lo, 32'hFFFFFFFF);
        check("divz_hi", hi, 32'h5);

        // MTHI then MFHI
        run(EXE_MTHI_OP, EXE_RES_NOP, 32'h12345678, 32'h0, 5'd0, 1'b1, 32'h0, 1'b0, 1'b0);
        run(EXE_MFHI_OP, EXE_RES_MOVE, 32'h0, 32'h0, 5'd8, 1'b1, 32'h12345678, 1'b1, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #2;

        // back-pressure
        out_ready = 1'b0;
        run(EXE_SLL_OP, EXE_RES_SHIFT, 32'h1, 32'h4, 5'd7, 1'b1, 32'h10, 1'b1, 1'b0);
        repeat (5) begin
            @(negedge clk);
            check("bp_wdata", wdata_out, 32'h10);
            check("bp_out_valid", 32'(out_valid), 1);
            check("bp_in_ready", 32'(in_ready), 0);
        end
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check("bp_release_out_valid", 32'(out_valid), 0);
        check("bp_release_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #2;

        // reset on the 10th ITER cycle of a divide
        issue(EXE_DIVU_OP, EXE_RES_NOP, 32'd100, 32'd3, 5'd0, 1'b0);
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #2;
        check("rstdiv_busy", 32'(busy), 0);
        check("rstdiv_hi", hi, 0);
        check("rstdiv_lo", lo, 0);
        check("rstdiv_out_valid", 32'(out_valid), 0);
        rst = 1'b1;
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rstdiv_no_result", 32'(seen), 0);
        check("scoreboard_empty", 32'(sbq.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
